// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode constants, default word width and the link
// state enumeration used by both ends of the mode-0 SPI link.
package spi_pkg;

    localparam logic SPI_CPOL           = 1'b0;
    localparam logic SPI_CPHA           = 1'b0;
    localparam int   SPI_DATA_WIDTH_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with an extra
// registered copy of the synchronised level used to produce single-cycle
// rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the raw input through the synchroniser chain and keep one delayed copy.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_rx_mode0.sv
// SPI mode-0 slave receiver: oversamples CS/SCLK/MOSI on the system clock,
// shifts MOSI in MSB-first on SCLK rising edges and reports each complete
// word, the end of each CS frame and frames cut short mid-word.
module spi_slave_rx_mode0
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  In_clk,
    input  logic                  In_rst_n,
    input  logic                  In_spi_cs_n,
    input  logic                  In_spi_sclk,
    input  logic                  In_spi_mosi,
    output logic [DATA_WIDTH-1:0] Out_rx_data,
    output logic                  Out_rx_valid,
    output logic                  Out_rx_first,
    output logic                  Out_frame_end,
    output logic                  Out_frag_err
);

    localparam int               CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic cs_sync_s;
    logic cs_rise_s;
    logic unused_cs_fall;
    logic sclk_rise_s;
    logic unused_sclk_level;
    logic unused_sclk_fall;
    logic mosi_sync_s;

    logic [SYNC_STAGES-1:0] mosi_sync_q;

    spi_state_e            state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  last_bit_s;
    logic                  first_q;

    // Events decided by the FSM, turned into output pulses one cycle later.
    logic evt_done_q;
    logic evt_first_q;
    logic evt_end_q;
    logic evt_frag_q;

    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  rx_first_q;
    logic                  frame_end_q;
    logic                  frag_err_q;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk_i   (In_clk),
        .rst_n_i (In_rst_n),
        .d_i     (In_spi_cs_n),
        .q_o     (cs_sync_s),
        .rise_o  (cs_rise_s),
        .fall_o  (unused_cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk_i   (In_clk),
        .rst_n_i (In_rst_n),
        .d_i     (In_spi_sclk),
        .q_o     (unused_sclk_level),
        .rise_o  (sclk_rise_s),
        .fall_o  (unused_sclk_fall)
    );

    // MOSI synchroniser, same depth as CS/SCLK so data lines up with the edge pulse.
    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], In_spi_mosi};
        end
    end

    assign mosi_sync_s = mosi_sync_q[SYNC_STAGES-1];

    // Next shift-register contents and bit counter for an SCLK rising edge.
    always_comb begin
        last_bit_s = (cnt_q == CNT_LAST);
        shift_d    = {shift_q[DATA_WIDTH-2:0], mosi_sync_s};
        if (sclk_rise_s) begin
            if (last_bit_s) begin
                cnt_d = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Frame FSM: shifts bits in while CS is low and flags word/frame events.
    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= {DATA_WIDTH{1'b0}};
            cnt_q       <= CNT_ZERO;
            first_q     <= 1'b1;
            evt_done_q  <= 1'b0;
            evt_first_q <= 1'b0;
            evt_end_q   <= 1'b0;
            evt_frag_q  <= 1'b0;
        end else begin
            evt_done_q  <= 1'b0;
            evt_first_q <= 1'b0;
            evt_end_q   <= 1'b0;
            evt_frag_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q   <= CNT_ZERO;
                    first_q <= 1'b1;
                    if (!cs_sync_s) begin
                        state_q <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_d;
                    if (sclk_rise_s) begin
                        shift_q <= shift_d;
                        if (last_bit_s) begin
                            evt_done_q  <= 1'b1;
                            evt_first_q <= first_q;
                            first_q     <= 1'b0;
                        end else begin
                            first_q <= first_q;
                        end
                    end else begin
                        shift_q <= shift_q;
                    end
                    // A word finishing on the same cycle as CS rise is complete, not a fragment.
                    if (cs_rise_s) begin
                        state_q    <= ST_IDLE;
                        evt_end_q  <= 1'b1;
                        evt_frag_q <= (cnt_d != CNT_ZERO);
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered outputs: publish the completed word and the frame pulses.
    always_ff @(posedge In_clk or negedge In_rst_n) begin
        if (!In_rst_n) begin
            rx_data_q   <= {DATA_WIDTH{1'b0}};
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            frame_end_q <= 1'b0;
            frag_err_q  <= 1'b0;
        end else begin
            if (evt_done_q) begin
                rx_data_q <= shift_q;
            end else begin
                rx_data_q <= rx_data_q;
            end
            rx_valid_q  <= evt_done_q;
            rx_first_q  <= evt_done_q & evt_first_q;
            frame_end_q <= evt_end_q;
            frag_err_q  <= evt_frag_q;
        end
    end

    assign Out_rx_data   = rx_data_q;
    assign Out_rx_valid  = rx_valid_q;
    assign Out_rx_first  = rx_first_q;
    assign Out_frame_end = frame_end_q;
    assign Out_frag_err  = frag_err_q;

endmodule

// File: tb/tb_spi_slave_rx_mode0.sv
// Self-checking bench for spi_slave_rx_mode0: a bit-banged SPI mode-0 master
// pushes expected words/frame events into a scoreboard queue and a monitor
// pops and compares them as the receiver reports them.
module tb_spi_slave_rx_mode0;

    localparam int LATENCY = 4;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       frame_end;
    logic       frag_err;

    typedef struct {
        int         kind;   // 0 = word, 1 = frame end
        logic [7:0] data;
        logic       first;
        logic       frag;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    spi_slave_rx_mode0 dut (
        .In_clk        (clk),
        .In_rst_n      (rst_n),
        .In_spi_cs_n   (cs_n),
        .In_spi_sclk   (sclk),
        .In_spi_mosi   (mosi),
        .Out_rx_data   (rx_data),
        .Out_rx_valid  (rx_valid),
        .Out_rx_first  (rx_first),
        .Out_frame_end (frame_end),
        .Out_frag_err  (frag_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rx_valid) begin
                check_eq("valid_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("valid_kind", 0, e.kind);
                    check_eq("rx_data", rx_data, e.data);
                    check_eq("rx_first", rx_first, e.first);
                    check_eq("latency_cyc", cyc, e.cyc);
                end
            end
            if (frame_end) begin
                check_eq("end_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("end_kind", 1, e.kind);
                    check_eq("frag_err", frag_err, e.frag);
                end
            end
            if (rx_valid || frame_end || frag_err || rx_first) begin
                check_eq("first_qual", rx_first && !rx_valid, 0);
                check_eq("frag_wo_end", frag_err && !frame_end, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] data, input int nbits, input int half,
                             input logic first);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = data[i];
            tick(half);
            sclk = 1'b1;
            if (i == 0) begin
                exp_q.push_back('{0, data, first, 1'b0, cyc + LATENCY});
            end
            tick(half);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low(input int half);
        cs_n = 1'b0;
        tick(half);
    endtask

    task automatic cs_high(input logic frag, input int half);
        cs_n = 1'b1;
        exp_q.push_back('{1, 8'h00, 1'b0, frag, 0});
        tick(2 * half + 8);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic check_outs_zero(input string tag);
        check_eq({tag, "_data"}, rx_data, 8'h00);
        check_eq({tag, "_valid"}, rx_valid, 0);
        check_eq({tag, "_first"}, rx_first, 0);
        check_eq({tag, "_end"}, frame_end, 0);
        check_eq({tag, "_frag"}, frag_err, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        tick(3);
        @(negedge clk);
        check_outs_zero("reset");
        rst_n = 1'b1;
        tick(5);

        // Single word at 50 kHz SCLK.
        cs_low(500);
        send_bits(8'hA5, 8, 500, 1'b1);
        cs_high(1'b0, 20);
        drain("drain_a5");

        // Two words in one frame.
        cs_low(20);
        send_bits(8'h3C, 8, 20, 1'b1);
        send_bits(8'hC3, 8, 20, 1'b0);
        cs_high(1'b0, 20);
        drain("drain_3c_c3");

        // Fragment: 5 bits then CS rise; data must hold.
        cs_low(20);
        send_bits(8'hFF, 5, 20, 1'b0);
        cs_high(1'b1, 20);
        drain("drain_frag");
        check_eq("hold_after_frag", rx_data, 8'hC3);
        cs_low(20);
        send_bits(8'h81, 8, 20, 1'b1);
        cs_high(1'b0, 20);
        drain("drain_81");

        // SCLK activity with CS high is ignored; an empty frame is not a fragment.
        mosi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sclk = ~sclk;
            tick(4);
        end
        tick(10);
        check_eq("idle_sclk_data", rx_data, 8'h81);
        cs_low(8);
        cs_high(1'b0, 8);
        drain("drain_empty_frame");

        // Reset in the middle of a word.
        cs_low(20);
        send_bits(8'hF0, 4, 20, 1'b0);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        @(negedge clk);
        check_outs_zero("midreset");
        tick(3);
        rst_n = 1'b1;
        tick(10);
        check_eq("post_reset_data", rx_data, 8'h00);
        cs_low(20);
        send_bits(8'h5A, 8, 20, 1'b1);
        cs_high(1'b0, 20);
        drain("drain_5a");

        // Minimum legal SCLK: 4 cycles high, 4 low, back-to-back words.
        cs_low(4);
        send_bits(8'h00, 8, 4, 1'b1);
        send_bits(8'hFF, 8, 4, 1'b0);
        cs_high(1'b0, 4);
        drain("drain_min_sclk");
        check_eq("final_data", rx_data, 8'hFF);

        tick(5);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx_mode0.md
Name: spi_slave_rx_mode0

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) slave receiver; the far end of the team's SPI master TX mode-0 link.
- Oversamples Out_spi_cs_n / Out_spi_sclk / Out_spi_mosi from the master on the system clock and deserialises MSB-first words.
- Presents each word with a one-cycle valid strobe, plus frame-start/frame-end and fragment-error flags, for downstream register or FIFO logic.

Parameters:
- DATA_WIDTH, 8, bits per SPI word, MSB first.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; minimum 2.

Ports:
- In_clk  input  1  system clock (50 MHz nominal).
- In_rst_n  input  1  reset; asynchronous, active-low.
- In_spi_cs_n  input  1  chip select from master, active-low, asynchronous to In_clk.
- In_spi_sclk  input  1  SPI clock from master, idle low.
- In_spi_mosi  input  1  serial data from master.
- Out_rx_data  output  DATA_WIDTH  last completed word; held until the next word completes.
- Out_rx_valid  output  1  one-cycle pulse, Out_rx_data newly updated.
- Out_rx_first  output  1  qualifies Out_rx_valid: word is the first of its CS frame.
- Out_frame_end  output  1  one-cycle pulse on CS deassertion.
- Out_frag_err  output  1  one-cycle pulse: CS deasserted with 1..DATA_WIDTH-1 bits shifted.

Behaviour:
- Clocking and reset: one clock domain (In_clk). Reset is asynchronous, active-low (In_rst_n).
- Reset values:
  - all outputs 0;
  - shift register 0, bit counter 0, first-flag 1;
  - synchroniser stages: CS to 1, SCLK to 0, MOSI to 0.
- Input synchronisation:
  - CS, SCLK and MOSI each pass through SYNC_STAGES flops, equal delay on all three.
  - One extra registered copy of SCLK and of CS provides edge detection.
- Timing requirement: SCLK high and low phases each at least 4 In_clk cycles. Faster SCLK is unsupported and not detected.
- State machine:
  - IDLE: entered when synchronised CS is high. Counter cleared, first-flag set. SCLK edges ignored.
  - IDLE -> SHIFT: on the cycle synchronised CS is sampled low.
  - SHIFT, on each synchronised SCLK rising edge:
    - shift_reg = {shift_reg[DATA_WIDTH-2:0], mosi_sync};
    - counter increments.
  - Word complete: on the edge where the counter reaches DATA_WIDTH-1 (the last bit):
    - next cycle, Out_rx_data = completed word;
    - Out_rx_valid = 1 for one cycle;
    - Out_rx_first = first-flag;
    - then first-flag cleared and counter reset to 0.
  - SCLK falling edges: no action (mode 0, the master changes MOSI on falling edges).
  - SHIFT -> IDLE: on the synchronised CS rising edge.
    - Out_frame_end pulses for one cycle.
    - If counter != 0, Out_frag_err pulses in the same cycle and the partial word is discarded; Out_rx_data is unchanged.
- Latency: last SCLK rising edge at pin -> Out_rx_valid high after SYNC_STAGES+2 In_clk cycles (4 with the default).
- Simultaneous events:
  - A final-bit edge and a CS rise detected in the same cycle: the word is completed and reported valid, frame_end pulses in the same cycle, frag_err = 0.
  - A CS fall in the same cycle as an SCLK rise: the edge is ignored (still IDLE).
- Out_rx_first is 0 whenever Out_rx_valid is 0.
- Reset mid-word: all state is discarded immediately. No valid, frame_end or err pulse occurs on or after reset release until a new CS assertion.

Decomposition:
- Shared package spi_pkg:
  - SPI mode constants (CPOL/CPHA);
  - default DATA_WIDTH;
  - the state enumeration (IDLE, SHIFT), shared with the master TX.
- One natural sub-module: spi_sync_edge.
  - A SYNC_STAGES synchroniser with rise/fall pulse outputs.
  - Instantiated for CS and SCLK; MOSI uses a plain synchroniser of equal depth.

Test Plan:
- 50 MHz In_clk, master at 50 kHz, CS low, sends 0xA5 -> exactly one Out_rx_valid with Out_rx_data=0xA5 and Out_rx_first=1; frame_end pulse after CS rise; frag_err=0.
- One frame with 0x3C then 0xC3 -> two valid pulses with first=1 then first=0, data 0x3C then 0xC3; one frame_end.
- CS raised after 5 bits of 0xFF -> frag_err and frame_end pulse together, no valid, Out_rx_data keeps its prior value. A following frame carrying 0x81 receives 0x81 with first=1.
- SCLK toggled 16 times with CS high, MOSI=1 -> no valid, no err, counter stays 0.
- In_rst_n low for 3 cycles after 4 bits of a word, then a full frame with 0x5A -> outputs 0 during reset; afterwards 0x5A received cleanly with first=1.
- Minimum legal SCLK (4 cycles high / 4 low), back-to-back words 0x00, 0xFF -> both received correctly, valid latency exactly 4 In_clk cycles after each 8th pin rising edge.
